// File: rtl/neighbor_table_update.sv
// Merges one neighbour beacon into the 64-entry neighbour table in shared memory.
// Updates a matching entry, or inserts into the lowest free slot.
module neighbor_table_update #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned NUM_NEIGHBORS = 64,
  parameter logic [WORD_WIDTH-1:0] NID_BASE  = 16'h48,
  parameter logic [WORD_WIDTH-1:0] CID_BASE  = 16'hC8,
  parameter logic [WORD_WIDTH-1:0] BATT_BASE = 16'h148,
  parameter logic [WORD_WIDTH-1:0] Q_BASE    = 16'h1C8,
  parameter logic [WORD_WIDTH-1:0] EMPTY_ID  = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] beacon_id,
  input  logic [WORD_WIDTH-1:0] beacon_cid,
  input  logic [WORD_WIDTH-1:0] beacon_batt,
  input  logic [WORD_WIDTH-1:0] beacon_q,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] slot,
  output logic [1:0]            status,
  output logic                  done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_WR_NID  = 3'd2;
  localparam logic [2:0] S_WR_CID  = 3'd3;
  localparam logic [2:0] S_WR_BATT = 3'd4;
  localparam logic [2:0] S_WR_Q    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [WORD_WIDTH-1:0] LAST_IDX =
    WORD_WIDTH'(NUM_NEIGHBORS - 1);

  logic [2:0]            state;
  logic [WORD_WIDTH-1:0] idx;
  logic [WORD_WIDTH-1:0] free_idx;
  logic                  have_free;
  logic [WORD_WIDTH-1:0] id_q;
  logic [WORD_WIDTH-1:0] cid_q;
  logic [WORD_WIDTH-1:0] batt_q;
  logic [WORD_WIDTH-1:0] q_q;

  logic                  is_last;
  logic                  hit;
  logic                  is_empty;
  logic                  free_any;
  logic [WORD_WIDTH-1:0] free_pick;
  logic [WORD_WIDTH-1:0] idx_nxt;

  function automatic logic [WORD_WIDTH-1:0] off(
    input logic [WORD_WIDTH-1:0] x
  );
    return {x[WORD_WIDTH-2:0], 1'b0};
  endfunction

  assign is_last   = (idx == LAST_IDX);
  assign hit       = (data_in == id_q);
  assign is_empty  = (data_in == EMPTY_ID);
  assign free_any  = have_free | is_empty;
  // The last entry can itself be the first free one.
  assign free_pick = have_free ? free_idx : idx;
  assign idx_nxt   = idx + WORD_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      address   <= NID_BASE;
      data_out  <= '0;
      wr_en     <= 1'b0;
      slot      <= '0;
      status    <= 2'd0;
      done      <= 1'b0;
      idx       <= '0;
      free_idx  <= '0;
      have_free <= 1'b0;
      id_q      <= '0;
      cid_q     <= '0;
      batt_q    <= '0;
      q_q       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            id_q      <= beacon_id;
            cid_q     <= beacon_cid;
            batt_q    <= beacon_batt;
            q_q       <= beacon_q;
            address   <= NID_BASE;
            idx       <= '0;
            free_idx  <= '0;
            have_free <= 1'b0;
            if (beacon_id == EMPTY_ID) begin
              status <= 2'd3;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (hit) begin
            slot     <= idx;
            status   <= 2'd0;
            address  <= CID_BASE + off(idx);
            data_out <= cid_q;
            wr_en    <= 1'b1;
            state    <= S_WR_CID;
          end else begin
            if (is_empty && !have_free) begin
              have_free <= 1'b1;
              free_idx  <= idx;
            end
            if (!is_last) begin
              idx     <= idx_nxt;
              address <= NID_BASE + off(idx_nxt);
            end else if (free_any) begin
              slot     <= free_pick;
              status   <= 2'd1;
              address  <= NID_BASE + off(free_pick);
              data_out <= id_q;
              wr_en    <= 1'b1;
              state    <= S_WR_NID;
            end else begin
              status <= 2'd2;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_WR_NID: begin
          address  <= CID_BASE + off(slot);
          data_out <= cid_q;
          state    <= S_WR_CID;
        end
        S_WR_CID: begin
          address  <= BATT_BASE + off(slot);
          data_out <= batt_q;
          state    <= S_WR_BATT;
        end
        S_WR_BATT: begin
          address  <= Q_BASE + off(slot);
          data_out <= q_q;
          state    <= S_WR_Q;
        end
        S_WR_Q: begin
          wr_en <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_table_update.sv
// Bench for neighbor_table_update: memory model plus table-level reference.
// Directed test-plan cases followed by random beacons against random tables.
module tb_neighbor_table_update;

  localparam logic [15:0] NID_B  = 16'h48;
  localparam logic [15:0] CID_B  = 16'hC8;
  localparam logic [15:0] BATT_B = 16'h148;
  localparam logic [15:0] Q_B    = 16'h1C8;
  localparam logic [15:0] EMPTY  = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] beacon_id = '0;
  logic [15:0] beacon_cid = '0;
  logic [15:0] beacon_batt = '0;
  logic [15:0] beacon_q = '0;
  logic [15:0] data_in;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wr_en;
  logic [15:0] slot;
  logic [1:0]  status;
  logic        done;

  logic [15:0] mem [0:65535];
  logic [15:0] m_nid  [64];
  logic [15:0] m_cid  [64];
  logic [15:0] m_batt [64];
  logic [15:0] m_q    [64];

  int total = 0;
  int bad = 0;

  neighbor_table_update dut (
    .clock(clock), .reset(reset), .start(start),
    .beacon_id(beacon_id), .beacon_cid(beacon_cid),
    .beacon_batt(beacon_batt), .beacon_q(beacon_q),
    .data_in(data_in), .address(address), .data_out(data_out),
    .wr_en(wr_en), .slot(slot), .status(status), .done(done)
  );

  always #5 clock = ~clock;

  assign data_in = mem[address];

  always @(posedge clock) begin
    if (wr_en) mem[address] <= data_out;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_tables();
    for (int i = 0; i < 64; i++) begin
      mem[NID_B + 16'(2*i)]  = m_nid[i];
      mem[CID_B + 16'(2*i)]  = m_cid[i];
      mem[BATT_B + 16'(2*i)] = m_batt[i];
      mem[Q_B + 16'(2*i)]    = m_q[i];
    end
  endtask

  task automatic fill_model(input logic [15:0] nid);
    for (int i = 0; i < 64; i++) begin
      m_nid[i]  = nid;
      m_cid[i]  = 16'(i + 16'h100);
      m_batt[i] = 16'(i + 16'h200);
      m_q[i]    = 16'(i + 16'h300);
    end
  endtask

  task automatic check_mem(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem[NID_B + 16'(2*i)] !== m_nid[i]) mism++;
      if (mem[CID_B + 16'(2*i)] !== m_cid[i]) mism++;
      if (mem[BATT_B + 16'(2*i)] !== m_batt[i]) mism++;
      if (mem[Q_B + 16'(2*i)] !== m_q[i]) mism++;
    end
    check(tag, mism, 0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] id,
                        input logic [15:0] cid, input logic [15:0] batt,
                        input logic [15:0] q, input bit early_drop);
    int found, free, e_st, e_slot, e_lat, e_wr, n, nwr;
    bit addr_ok;
    found = -1;
    free = -1;
    for (int i = 0; i < 64; i++) begin
      if (found < 0 && m_nid[i] == id) found = i;
      if (free < 0 && m_nid[i] == EMPTY) free = i;
    end
    e_slot = 0;
    if (id == EMPTY) begin
      e_st = 3; e_lat = 0; e_wr = 0;
    end else if (found >= 0) begin
      e_st = 0; e_slot = found; e_lat = found + 4; e_wr = 3;
    end else if (free >= 0) begin
      e_st = 1; e_slot = free; e_lat = 68; e_wr = 4;
      m_nid[free] = id;
    end else begin
      e_st = 2; e_lat = 64; e_wr = 0;
    end
    if (e_wr != 0) begin
      m_cid[e_slot] = cid;
      m_batt[e_slot] = batt;
      m_q[e_slot] = q;
    end

    @(negedge clock);
    beacon_id = id; beacon_cid = cid;
    beacon_batt = batt; beacon_q = q;
    start = 1'b1;
    @(posedge clock);
    #1;
    beacon_id = 16'($urandom); beacon_cid = 16'($urandom);
    beacon_batt = 16'($urandom); beacon_q = 16'($urandom);
    if (early_drop) start = 1'b0;
    n = 0; nwr = 0; addr_ok = 1'b1;
    while (!done && n < 200) begin
      if (wr_en) nwr++;
      if (address !== NID_B) addr_ok = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, ".latency"}, n, e_lat);
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".status"}, int'(status), e_st);
    if (e_st < 2) check({tag, ".slot"}, int'(slot), e_slot);
    check({tag, ".writes"}, nwr, e_wr);
    if (e_st == 3) check({tag, ".addr_stay"}, int'(addr_ok), 1);
    if (early_drop) begin
      @(posedge clock);
      #1;
      check({tag, ".done_exit"}, int'(done), 0);
    end else begin
      @(posedge clock);
      #1;
      check({tag, ".done_hold"}, int'(done), 1);
      check({tag, ".idle_wr"}, int'(wr_en), 0);
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      #1;
      check({tag, ".done_exit"}, int'(done), 0);
    end
    check_mem({tag, ".mem"});
  endtask

  initial begin
    int n;
    logic [15:0] rid;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;

    // Reset values
    @(posedge clock);
    #1;
    check("rst.address", int'(address), int'(NID_B));
    check("rst.wr_en", int'(wr_en), 0);
    check("rst.done", int'(done), 0);
    check("rst.slot", int'(slot), 0);
    check("rst.status", int'(status), 0);
    check("rst.data_out", int'(data_out), 0);
    @(negedge clock);
    reset = 1'b0;

    fill_model(EMPTY);
    load_tables();
    run_op("ins_empty", 16'd5, 16'd2, 16'h3C00, 16'h3800, 1'b0);
    check("ins_empty.nid0", int'(mem[16'h48]), 5);
    check("ins_empty.q0", int'(mem[16'h1C8]), 16'h3800);

    for (int i = 0; i < 64; i++) m_nid[i] = 16'(100 + i);
    m_nid[10] = 16'd7;
    load_tables();
    run_op("upd10", 16'd7, 16'd3, 16'h1111, 16'h2222, 1'b0);
    check("upd10.cid", int'(mem[16'hDC]), 3);

    m_nid[10] = 16'd110;
    m_nid[3] = 16'd7;
    m_nid[9] = 16'd7;
    load_tables();
    run_op("dup", 16'd7, 16'd9, 16'h4444, 16'h5555, 1'b0);
    check("dup.e9_cid", int'(mem[CID_B + 16'd18]), int'(m_cid[9]));

    run_op("full", 16'd42, 16'd1, 16'd2, 16'd3, 1'b0);
    run_op("invalid", EMPTY, 16'd1, 16'd2, 16'd3, 1'b0);
    run_op("invalid_drop", EMPTY, 16'd1, 16'd2, 16'd3, 1'b1);
    run_op("full_drop", 16'd43, 16'd1, 16'd2, 16'd3, 1'b1);

    // Reset during WR_BATT of an insert into slot 20
    m_nid[20] = EMPTY;
    load_tables();
    @(negedge clock);
    beacon_id = 16'd77; beacon_cid = 16'hAB;
    beacon_batt = 16'hCD; beacon_q = 16'hEF;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(wr_en && address == BATT_B + 16'd40) && n < 200);
    check("rstmid.reach", int'(n < 200), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid.wr_en", int'(wr_en), 0);
    check("rstmid.address", int'(address), int'(NID_B));
    check("rstmid.status", int'(status), 0);
    check("rstmid.slot", int'(slot), 0);
    check("rstmid.done", int'(done), 0);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_nid[20] = 16'd77;
    m_cid[20] = 16'hAB;
    check_mem("rstmid.mem");
    run_op("rstmid.reupd", 16'd77, 16'h55, 16'h66, 16'h88, 1'b0);

    // Random beacons against random tables
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 64; i++) begin
        m_nid[i] = ($urandom_range(3) == 0) ? EMPTY
                   : 16'($urandom_range(40));
        m_cid[i] = 16'($urandom);
        m_batt[i] = 16'($urandom);
        m_q[i] = 16'($urandom);
      end
      if (t % 4 == 3) begin
        for (int i = 0; i < 64; i++) m_nid[i] = 16'(200 + i);
      end
      load_tables();
      rid = ($urandom_range(9) == 0) ? EMPTY : 16'($urandom_range(45));
      run_op($sformatf("rnd%0d", t), rid, 16'($urandom),
             16'($urandom), 16'($urandom), bit'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
